// File: rtl/i2s_tdm_clkgen.sv
// I2S/TDM bit-clock and frame-sync generator; all outputs registered, config shadowed at frame boundaries.
// Latency: first bclk_fall/frame_start one mclki after enable is sampled; no backpressure (free-running).
// Optional macro I2S_TDM_CLKGEN_POLARITY_EN adds shadowed bclk/lrck pin inversion.
module i2s_tdm_clkgen #(
  parameter int DIV_W     = 8,
  parameter int MAX_SLOTS = 16,
  parameter int SLOT_W    = $clog2(MAX_SLOTS)
) (
  input  logic              mclki,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  bclk_div,
  input  logic [5:0]        word_width,
  input  logic [SLOT_W:0]   slot_count,
  input  logic              fs_mode,
`ifdef I2S_TDM_CLKGEN_POLARITY_EN
  input  logic              bclk_inv,
  input  logic              lrck_inv,
`endif
  output logic              bclk,
  output logic              lrck,
  output logic              bclk_fall,
  output logic              bclk_rise,
  output logic              frame_start,
  output logic [SLOT_W-1:0] slot_idx,
  output logic [4:0]        bit_idx,
  output logic              running
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam logic [SLOT_W:0] MAX_S = (SLOT_W+1)'(MAX_SLOTS);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  hc_q, hc_d, div_q, div_d, div_c;
  logic              bclk_q, bclk_d, lrck_q, lrck_d;
  logic              fall_q, fall_d, rise_q, rise_d, fs_q, fs_d;
  logic [SLOT_W-1:0] slot_q, slot_d, slot_inc, last_slot;
  logic [4:0]        bit_q, bit_d, wordm1_q, wordm1_d, wordm1_c;
  logic [SLOT_W:0]   slots_q, slots_d, slots_c, half;
  logic              mode_q, mode_d, load;
`ifdef I2S_TDM_CLKGEN_POLARITY_EN
  logic              binv_q, binv_d, linv_q, linv_d;
`endif

  always_comb begin
    div_c    = (bclk_div == '0) ? DIV_W'(1) : bclk_div;
    wordm1_c = (word_width < 6'd8)  ? 5'd7  :
               (word_width > 6'd32) ? 5'd31 : word_width[4:0] - 5'd1;
    slots_c  = (slot_count == '0)   ? (SLOT_W+1)'(1) :
               (slot_count > MAX_S) ? MAX_S : slot_count;
  end

  // A one-slot I2S frame runs as two slots so lrck still toggles every word.
  always_comb begin
    last_slot = (!mode_q && slots_q == (SLOT_W+1)'(1)) ? SLOT_W'(1)
                                                      : slots_q[SLOT_W-1:0] - 1'b1;
    half      = ({1'b0, last_slot} + 1'b1) >> 1;
    slot_inc  = slot_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    bclk_d  = bclk_q;
    lrck_d  = lrck_q;
    fall_d  = 1'b0;
    rise_d  = 1'b0;
    fs_d    = 1'b0;
    slot_d  = slot_q;
    bit_d   = bit_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        load   = 1'b1;
        hc_d   = '0;
        bclk_d = 1'b0;
        lrck_d = 1'b0;
        slot_d = '0;
        bit_d  = '0;
        if (enable) begin
          state_d = RUN;
          fall_d  = 1'b1;
          fs_d    = 1'b1;
          lrck_d  = fs_mode;
        end
      end
      default: begin
        state_d = enable ? RUN : STOPPING;
        if (hc_q != div_q - 1'b1) begin
          hc_d = hc_q + 1'b1;
        end else begin
          hc_d = '0;
          if (!bclk_q) begin
            bclk_d = 1'b1;
            rise_d = 1'b1;
          end else begin
            bclk_d = 1'b0;
            if (bit_q != wordm1_q) begin
              bit_d  = bit_q + 5'd1;
              fall_d = 1'b1;
              lrck_d = !mode_q && ({1'b0, slot_q} >= half);
            end else if (slot_q != last_slot) begin
              bit_d  = '0;
              slot_d = slot_inc;
              fall_d = 1'b1;
              lrck_d = !mode_q && ({1'b0, slot_inc} >= half);
            end else if (!enable) begin
              // Frame boundary while stopping: park instead of starting a frame.
              state_d = IDLE;
              lrck_d  = 1'b0;
              bit_d   = '0;
              slot_d  = '0;
              load    = 1'b1;
            end else begin
              load   = 1'b1;
              bit_d  = '0;
              slot_d = '0;
              fall_d = 1'b1;
              fs_d   = 1'b1;
              lrck_d = fs_mode;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    div_d    = load ? div_c    : div_q;
    wordm1_d = load ? wordm1_c : wordm1_q;
    slots_d  = load ? slots_c  : slots_q;
    mode_d   = load ? fs_mode  : mode_q;
`ifdef I2S_TDM_CLKGEN_POLARITY_EN
    binv_d   = load ? bclk_inv : binv_q;
    linv_d   = load ? lrck_inv : linv_q;
`endif
  end

  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hc_q     <= '0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      fall_q   <= 1'b0;
      rise_q   <= 1'b0;
      fs_q     <= 1'b0;
      slot_q   <= '0;
      bit_q    <= '0;
      div_q    <= DIV_W'(1);
      wordm1_q <= 5'd7;
      slots_q  <= (SLOT_W+1)'(1);
      mode_q   <= 1'b0;
`ifdef I2S_TDM_CLKGEN_POLARITY_EN
      binv_q   <= 1'b0;
      linv_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      fall_q   <= fall_d;
      rise_q   <= rise_d;
      fs_q     <= fs_d;
      slot_q   <= slot_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      wordm1_q <= wordm1_d;
      slots_q  <= slots_d;
      mode_q   <= mode_d;
`ifdef I2S_TDM_CLKGEN_POLARITY_EN
      binv_q   <= binv_d;
      linv_q   <= linv_d;
`endif
    end
  end

`ifdef I2S_TDM_CLKGEN_POLARITY_EN
  assign bclk = bclk_q ^ binv_q;
  assign lrck = lrck_q ^ linv_q;
`else
  assign bclk = bclk_q;
  assign lrck = lrck_q;
`endif
  assign bclk_fall   = fall_q;
  assign bclk_rise   = rise_q;
  assign frame_start = fs_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;
  assign running     = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_tdm_clkgen.sv
// Bench for i2s_tdm_clkgen: frame-level reference model feeds a queue of expected bclk_fall/stop events,
// an independent monitor checks every mclki cycle against it.
module tb_i2s_tdm_clkgen;

  logic       mclki = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] bclk_div = 8'd4;
  logic [5:0] word_width = 6'd32;
  logic [4:0] slot_count = 5'd2;
  logic       fs_mode = 1'b0;
  logic       bclk, lrck, bclk_fall, bclk_rise, frame_start, running;
  logic [3:0] slot_idx;
  logic [4:0] bit_idx;

  i2s_tdm_clkgen #(.DIV_W(8), .MAX_SLOTS(16)) dut (
    .mclki(mclki), .rst_n(rst_n), .enable(enable), .bclk_div(bclk_div),
    .word_width(word_width), .slot_count(slot_count), .fs_mode(fs_mode),
`ifdef I2S_TDM_CLKGEN_POLARITY_EN
    .bclk_inv(1'b0), .lrck_inv(1'b0),
`endif
    .bclk(bclk), .lrck(lrck), .bclk_fall(bclk_fall), .bclk_rise(bclk_rise),
    .frame_start(frame_start), .slot_idx(slot_idx), .bit_idx(bit_idx), .running(running)
  );

  always #5 mclki = ~mclki;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit stop;
    int gap;
    int div;
    int slot;
    int bitn;
    bit lrck;
    bit fs;
  } exp_t;

  exp_t exp_q[$];
  int   model_div = 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // One frame of expected falling-edge events, straight from the frame rules.
  task automatic push_frame(input int dv, input int w_in, input int s_in, input int m, input bit first);
    int   d, w, s;
    exp_t e;
    d = (dv == 0) ? 1 : dv;
    w = clampi(w_in, 8, 32);
    s = clampi(s_in, 1, 16);
    if (m == 0 && s == 1) s = 2;
    for (int sl = 0; sl < s; sl++) begin
      for (int b = 0; b < w; b++) begin
        e.stop = 1'b0;
        e.div  = d;
        e.slot = sl;
        e.bitn = b;
        e.fs   = (sl == 0 && b == 0);
        e.lrck = (m != 0) ? e.fs : (sl >= s / 2);
        if (sl == 0 && b == 0) e.gap = first ? 0 : 2 * model_div;
        else                   e.gap = 2 * d;
        exp_q.push_back(e);
      end
    end
    model_div = d;
  endtask

  task automatic push_stop();
    exp_t e;
    e = '{stop: 1'b1, gap: 2 * model_div, div: model_div, slot: 0, bitn: 0, lrck: 1'b0, fs: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic set_cfg(input int dv, input int w, input int s, input int m, input bit first);
    bclk_div   = dv[7:0];
    word_width = w[5:0];
    slot_count = s[4:0];
    fs_mode    = m[0];
    push_frame(dv, w, s, m, first);
  endtask

  task automatic rand_cfg(output int dv, output int w, output int s, output int m);
    dv = $urandom_range(0, 4);
    w  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(8, 32);
    s  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 6);
    m  = $urandom_range(0, 1);
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    do begin
      @(negedge mclki);
      n++;
    end while (!frame_start && n < 20000);
    if (!frame_start) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_stop();
    int n = 0;
    while (running && n < 20000) begin
      @(negedge mclki);
      n++;
    end
    chk("stop_timeout", running, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bclk"}, bclk, 0);
    chk({tag, "_lrck"}, lrck, 0);
    chk({tag, "_bclk_fall"}, bclk_fall, 0);
    chk({tag, "_bclk_rise"}, bclk_rise, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_slot_idx"}, slot_idx, 0);
    chk({tag, "_bit_idx"}, bit_idx, 0);
    chk({tag, "_running"}, running, 0);
  endtask

  initial begin : monitor
    int   since;
    int   cur_div;
    logic lrck_prev, run_prev;
    exp_t e;
    since = 0; cur_div = 1; lrck_prev = 1'b0; run_prev = 1'b0;
    forever begin
      @(negedge mclki);
      if (!rst_n) begin
        since = 0; lrck_prev = 1'b0; run_prev = 1'b0;
        continue;
      end
      since++;
      if (bclk_fall) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fall", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("fall_is_not_stop", e.stop, 0);
          chk("slot_idx", slot_idx, e.slot);
          chk("bit_idx", bit_idx, e.bitn);
          chk("lrck", lrck, e.lrck);
          chk("frame_start", frame_start, e.fs);
          if (e.gap != 0) chk("fall_gap", since, e.gap);
          cur_div = e.div;
        end
        since = 0;
      end else begin
        if (run_prev && !running) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_stop", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("stop_expected", e.stop, 1);
            chk("stop_gap", since, e.gap);
            chk("stop_lrck", lrck, 0);
          end
        end else begin
          chk("lrck_stable", lrck, lrck_prev);
        end
        chk("fs_without_fall", frame_start, 0);
        chk("bclk_rise", bclk_rise, (running && since == cur_div) ? 1 : 0);
      end
      chk("bclk_level", bclk, (running && since >= cur_div) ? 1 : 0);
      lrck_prev = lrck;
      run_prev  = running;
    end
  end

  initial begin : stim
    int cdv[$], cw[$], cs[$], cm[$];
    int dv, w, s, m, n;

    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge mclki);
    rst_n = 1'b1;
    repeat (3) @(negedge mclki);
    check_all_zero("idle_after_reset");

    // Directed frames first, then random ones, then a short 4-slot frame to stop in.
    cdv = '{4, 2, 4, 1, 1, 0};
    cw  = '{32, 16, 16, 16, 32, 40};
    cs  = '{2, 8, 2, 2, 2, 0};
    cm  = '{0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      rand_cfg(dv, w, s, m);
      cdv.push_back(dv); cw.push_back(w); cs.push_back(s); cm.push_back(m);
    end
    cdv.push_back(1); cw.push_back(8); cs.push_back(4); cm.push_back(0);

    set_cfg(cdv[0], cw[0], cs[0], cm[0], 1'b1);
    enable = 1'b1;
    for (int i = 1; i < cdv.size(); i++) begin
      wait_fs("fs_run");
      repeat (2) @(negedge mclki);
      set_cfg(cdv[i], cw[i], cs[i], cm[i], 1'b0);
      if (i == 3 || (i >= 6 && $urandom_range(0, 2) == 0)) begin
        repeat (2) @(negedge mclki);
        enable = 1'b0;
        repeat (3) @(negedge mclki);
        enable = 1'b1;
      end
    end

    wait_fs("fs_last");
    n = 0;
    while (!(slot_idx == 4'd1 && bit_idx == 5'd5) && n < 20000) begin
      @(negedge mclki);
      n++;
    end
    chk("reach_slot1_bit5", (slot_idx == 4'd1 && bit_idx == 5'd5) ? 1 : 0, 1);
    enable = 1'b0;
    push_stop();
    wait_stop();
    repeat (4) @(negedge mclki);
    check_all_zero("idle_after_stop");

    rand_cfg(dv, w, s, m);
    set_cfg(dv, w, s, m, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_fs("fs_run2");
      repeat (2) @(negedge mclki);
      rand_cfg(dv, w, s, m);
      set_cfg(dv, w, s, m, 1'b0);
      if ($urandom_range(0, 1) == 0) begin
        repeat (2) @(negedge mclki);
        enable = 1'b0;
        repeat (3) @(negedge mclki);
        enable = 1'b1;
      end
    end

    wait_fs("fs_before_reset");
    repeat ($urandom_range(3, 10)) @(negedge mclki);
    @(posedge mclki);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    @(negedge mclki);
    rand_cfg(dv, w, s, m);
    set_cfg(dv, w, s, m, 1'b1);
    enable = 1'b1;
    rst_n  = 1'b1;
    @(negedge mclki);
    chk("fs_after_reset_release", frame_start, 1);
    chk("running_after_reset_release", running, 1);
    repeat (2) @(negedge mclki);
    rand_cfg(dv, w, s, m);
    set_cfg(dv, w, s, m, 1'b0);
    wait_fs("fs_final");
    repeat (2) @(negedge mclki);
    enable = 1'b0;
    push_stop();
    wait_stop();
    repeat (5) @(negedge mclki);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
